green_sequence_monitor: RTL and testbench
=========================================

Name: green_sequence_monitor

Overview:
- Synthesizable run-time monitor for the intersection's NUM_CH green outputs.
- Records which ordered green-to-green handovers have occurred, flags simultaneous greens on conflicting channels, flags greens shorter than MIN_GREEN cycles, and counts green onsets.
- Sits beside the intersection controller and observes only; its outputs go to status/debug registers.

Parameters:
- NUM_CH, 4: number of green channels (index 0 pedestrian, 1 up, 2 down, 3 turn in the default build).
- MIN_GREEN, 2: minimum legal green run length in cycles, >=1.
- CNT_W, 16: width of the onset counter.
- CONFLICT_MASK, all ones except the diagonal: NUM_CH*NUM_CH bits; bit i*NUM_CH+j set means channels i and j must never be green together.
- REQ_MASK, all ones except the diagonal: NUM_CH*NUM_CH bits; the pairs that must be seen for all_pairs_seen.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- green  in  NUM_CH  green outputs of the controller, bit i = channel i.
- clear  in  1  synchronous clear of all recorded state.
- pair_seen  out  NUM_CH*NUM_CH  sticky; bit i*NUM_CH+j = handover i->j observed.
- all_pairs_seen  out  1  (pair_seen & REQ_MASK) == REQ_MASK.
- conflict_now  out  1  combinational; some masked pair is green this cycle.
- conflict  out  1  sticky, registered conflict_now.
- short_green  out  NUM_CH  sticky; bit i = a green run on channel i ended early.
- onset_count  out  CNT_W  saturating count of green rising edges.

Behaviour:
- Reset (reset low, asynchronous, also mid-operation):
  - Cleared to 0: armed, pair_seen, conflict, short_green, onset_count, green_q, run counters.
  - all_pairs_seen = 0 unless REQ_MASK = 0.
- armed[i][j], i != j: set at the clock edge where green[i] && !green[j]. It stays set until clear or reset.
- pair_seen[i][j] is set at the edge where armed[i][j] (registered value) && !green[i] && green[j].
  - Because armed is registered, the handover needs at least one cycle between the two conditions.
  - A cycle that both arms and completes the same pair cannot complete it.
- Diagonal bits of armed and pair_seen are constant 0.
- Several pairs may set in the same cycle.
- Run counter per channel:
  - Increments while green[i] is high and saturates at MIN_GREEN.
  - Loads 1 on a rising edge of green[i] and drops to 0 when green[i] is low.
- Short green: at a falling edge (green_q[i] && !green[i]), if the counter is < MIN_GREEN, set short_green[i].
  - With MIN_GREEN = 1 this flag can never fire.
- Conflict:
  - conflict_now = OR over i,j of CONFLICT_MASK[i*NUM_CH+j] && green[i] && green[j].
  - conflict is set at the edge where conflict_now is 1.
  - An asymmetric mask bit (i,j) is sufficient by itself to flag the conflict.
- Onset count:
  - onset_count += popcount(green & ~green_q) each cycle, saturating at 2^CNT_W-1.
  - It never wraps, including a multi-onset add near the limit.
- clear:
  - Zeroes armed, pair_seen, conflict, short_green and onset_count at the next edge.
  - Events in the clear cycle are discarded; recording resumes the following cycle.
  - green_q and the run counters are not cleared, so a green in progress during clear is not falsely counted or flagged.
- reset has priority over clear.
- Latency:
  - All sticky outputs appear one cycle after the causing sample.
  - conflict_now is zero-latency.
- No X propagation: all outputs are driven from flops or from the green input.

Test Plan:
- Reset release, green = 0 for 5 cycles -> every output 0, onset_count = 0.
- green 0001 for 3 cycles, then 0010 for 3 cycles:
  - pair_seen bit 1 (0->1) is set one cycle after the first 0010 sample.
  - Bits 0*4+2 and 0*4+3 are not set by this handover (green[2] and green[3] stay low).
  - onset_count = 2; no short_green.
- green 0100 for 1 cycle with MIN_GREEN = 2 -> short_green = 0100 the cycle after the falling edge. Repeat with a 2-cycle run -> no flag.
- green 1001 with the default mask -> conflict_now = 1 in the same cycle, conflict = 1 the next cycle and held after green returns to 0000.
- Cycle all 12 ordered handovers, each channel exclusively green for 2 cycles, with REQ_MASK excluding bit 3*4+0:
  - all_pairs_seen rises once the 11 required pairs are seen.
  - Assert clear -> everything except conflict_now returns to 0 the next cycle.
- CNT_W = 2, 4 onsets, then green 0000 -> 1111 -> onset_count holds at 3.
  - Pulse reset low between edges -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/green_sequence_monitor.sv
// Observe-only monitor for the intersection green outputs: records ordered
// green-to-green handovers, conflicting greens, short greens and green onsets.
module green_sequence_monitor #(
    parameter int NUM_CH    = 4,
    parameter int MIN_GREEN = 2,
    parameter int CNT_W     = 16,
    parameter logic [NUM_CH*NUM_CH-1:0] CONFLICT_MASK =
        ~{1'b1, {(NUM_CH-1){{NUM_CH{1'b0}}, 1'b1}}},
    parameter logic [NUM_CH*NUM_CH-1:0] REQ_MASK =
        ~{1'b1, {(NUM_CH-1){{NUM_CH{1'b0}}, 1'b1}}}
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          green,
    input  logic                       clear,
    output logic [NUM_CH*NUM_CH-1:0]   pair_seen,
    output logic                       all_pairs_seen,
    output logic                       conflict_now,
    output logic                       conflict,
    output logic [NUM_CH-1:0]          short_green,
    output logic [CNT_W-1:0]           onset_count
);

    localparam int PAIRS = NUM_CH * NUM_CH;
    localparam int RUN_W = $clog2(MIN_GREEN + 1);
    localparam int POP_W = $clog2(NUM_CH + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    localparam logic [RUN_W-1:0] MIN_RUN = RUN_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CH-1:0] green_q;
    logic [PAIRS-1:0]  armed;
    logic [RUN_W-1:0]  run_cnt [NUM_CH];

    logic [PAIRS-1:0]  arm_set;
    logic [PAIRS-1:0]  pair_set;
    logic [PAIRS-1:0]  both_green;
    logic [NUM_CH-1:0] onset;
    logic [NUM_CH-1:0] fall_short;
    logic [POP_W-1:0]  onset_pop;
    logic [SUM_W-1:0]  onset_sum;

    // Pair bit i*NUM_CH+j: armed when i is green without j, completed when j
    // is green without i after arming.
    always_comb begin
        // NOTE: every variable gets a default before the loops so no latch is inferred.
        arm_set    = '0;
        pair_set   = '0;
        both_green = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                both_green[i*NUM_CH+j] = green[i] && green[j];
                if (i != j) begin
                    arm_set[i*NUM_CH+j]  = green[i] && !green[j];
                    pair_set[i*NUM_CH+j] = armed[i*NUM_CH+j] && !green[i] && green[j];
                end
            end
        end
    end

    assign onset = green & ~green_q;

    always_comb begin
        onset_pop  = '0;
        fall_short = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            onset_pop     = onset_pop + POP_W'(onset[i]);
            fall_short[i] = green_q[i] && !green[i] && (run_cnt[i] < MIN_RUN);
        end
    end

    // Wide enough that a multi-onset add near the limit cannot wrap.
    assign onset_sum = SUM_W'(onset_count) + SUM_W'(onset_pop);

    assign conflict_now   = |(CONFLICT_MASK & both_green);
    assign all_pairs_seen = ((pair_seen & REQ_MASK) == REQ_MASK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            green_q     <= '0;
            armed       <= '0;
            pair_seen   <= '0;
            conflict    <= 1'b0;
            short_green <= '0;
            onset_count <= '0;
            // NOTE: the run counters are a few flops, not a RAM, so they are reset too.
            for (int i = 0; i < NUM_CH; i++) begin
                run_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            green_q <= green;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!green[i]) begin
                    run_cnt[i] <= '0;
                end else if (!green_q[i]) begin
                    run_cnt[i] <= RUN_W'(1);
                end else if (run_cnt[i] < MIN_RUN) begin
                    run_cnt[i] <= run_cnt[i] + 1'b1;
                end
            end

            // green_q and run counters keep tracking through clear so a green
            // in progress is neither recounted nor flagged afterwards.
            if (clear) begin
                armed       <= '0;
                pair_seen   <= '0;
                conflict    <= 1'b0;
                short_green <= '0;
                onset_count <= '0;
            end else begin
                armed       <= armed | arm_set;
                pair_seen   <= pair_seen | pair_set;
                short_green <= short_green | fall_short;
                if (conflict_now) begin
                    conflict <= 1'b1;
                end
                if (onset_sum > SUM_W'(CNT_MAX)) begin
                    onset_count <= CNT_MAX;
                end else begin
                    onset_count <= onset_sum[CNT_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_green_sequence_monitor.sv
// Self-checking bench: a default-build monitor and a small build (MIN_GREEN=1,
// CNT_W=2, pair 3->0 not required) run side by side against a rule-level model.
module tb_green_sequence_monitor;

    localparam int          N     = 4;
    localparam logic [15:0] CMASK = 16'h7BDE;
    localparam logic [15:0] REQ_A = 16'h7BDE;
    localparam logic [15:0] REQ_B = 16'h6BDE;
    localparam int          MIN_A = 2;
    localparam int          MIN_B = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] green = 4'b0000;
    logic       clear = 1'b0;

    logic [15:0] pair_seen_a, pair_seen_b;
    logic        all_pairs_a, all_pairs_b;
    logic        conflict_now_a, conflict_now_b;
    logic        conflict_a, conflict_b;
    logic [3:0]  short_a, short_b;
    logic [15:0] onset_a;
    logic [1:0]  onset_b;

    green_sequence_monitor dut_a (
        .clock(clock), .reset(reset), .green(green), .clear(clear),
        .pair_seen(pair_seen_a), .all_pairs_seen(all_pairs_a),
        .conflict_now(conflict_now_a), .conflict(conflict_a),
        .short_green(short_a), .onset_count(onset_a)
    );

    green_sequence_monitor #(
        .MIN_GREEN(1), .CNT_W(2), .REQ_MASK(16'h6BDE)
    ) dut_b (
        .clock(clock), .reset(reset), .green(green), .clear(clear),
        .pair_seen(pair_seen_b), .all_pairs_seen(all_pairs_b),
        .conflict_now(conflict_now_b), .conflict(conflict_b),
        .short_green(short_b), .onset_count(onset_b)
    );

    always #5 clock = ~clock;

    logic [37:0] obs_a;
    logic [23:0] obs_b;
    assign obs_a = {pair_seen_a, all_pairs_a, conflict_a, short_a, onset_a};
    assign obs_b = {pair_seen_b, all_pairs_b, conflict_b, short_b, onset_b};

    int n_vec = 0;
    int n_err = 0;

    // Reference model: handover, conflict, run-length and onset rules.
    bit          armed_m [N][N];
    bit [15:0]   m_pairs;
    bit          m_conflict;
    int          m_run [N];
    bit [3:0]    m_last, m_short_a, m_short_b;
    longint      m_total;

    function automatic logic exp_cn(input logic [3:0] g);
        exp_cn = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (CMASK[i*N+j] && g[i] && g[j]) exp_cn = 1'b1;
    endfunction

    function automatic logic [37:0] exp_a();
        logic [15:0] cnt;
        cnt = (m_total > 65535) ? 16'hFFFF : 16'(m_total);
        exp_a = {m_pairs, ((m_pairs & REQ_A) == REQ_A), m_conflict, m_short_a, cnt};
    endfunction

    function automatic logic [23:0] exp_b();
        logic [1:0] cnt;
        cnt = (m_total > 3) ? 2'd3 : 2'(m_total);
        exp_b = {m_pairs, ((m_pairs & REQ_B) == REQ_B), m_conflict, m_short_b, cnt};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) armed_m[i][j] = 1'b0;
        m_pairs    = '0;
        m_conflict = 1'b0;
        m_short_a  = '0;
        m_short_b  = '0;
        m_total    = 0;
    endtask

    task automatic model_reset();
        model_clear();
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_last = '0;
    endtask

    task automatic model_tick(input logic [3:0] g, input logic c);
        if (c) begin
            model_clear();
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (i != j && armed_m[i][j] && !g[i] && g[j]) m_pairs[i*N+j] = 1'b1;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (i != j && g[i] && !g[j]) armed_m[i][j] = 1'b1;
            if (exp_cn(g)) m_conflict = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (m_last[i] && !g[i]) begin
                    if (m_run[i] < MIN_A) m_short_a[i] = 1'b1;
                    if (m_run[i] < MIN_B) m_short_b[i] = 1'b1;
                end
                if (g[i] && !m_last[i]) m_total++;
            end
        end
        for (int i = 0; i < N; i++) m_run[i] = g[i] ? m_run[i] + 1 : 0;
        m_last = g;
    endtask

    task automatic drive(input logic [3:0] g, input logic c);
        @(negedge clock);
        green = g;
        clear = c;
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_reset();
        else        model_tick(green, clear);
        #1;
    endtask

    task automatic step(input logic [3:0] g, input logic c);
        drive(g, c);
        tick();
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) step(4'b0000, 1'b0);
        n_vec++;
        if (obs_a !== 38'h0) begin
            n_err++; $display("FAIL reset_a: got %h, want 0", obs_a);
        end
        n_vec++;
        if (obs_b !== 24'h0) begin
            n_err++; $display("FAIL reset_b: got %h, want 0", obs_b);
        end
        n_vec++;
        if (conflict_now_a !== 1'b0) begin
            n_err++; $display("FAIL reset_conflict_now: got %b, want 0", conflict_now_a);
        end
    endtask

    task automatic test_handover();
        repeat (3) step(4'b0001, 1'b0);
        n_vec++;
        if (pair_seen_a !== 16'h0000) begin
            n_err++; $display("FAIL handover_early: got %h, want 0000", pair_seen_a);
        end
        step(4'b0010, 1'b0);
        n_vec++;
        if (pair_seen_a !== 16'h0002) begin
            n_err++; $display("FAIL handover_0_1: got %h, want 0002", pair_seen_a);
        end
        repeat (2) step(4'b0010, 1'b0);
        n_vec++;
        if (pair_seen_a !== 16'h0002) begin
            n_err++; $display("FAIL handover_no_extra: got %h, want 0002", pair_seen_a);
        end
        n_vec++;
        if (onset_a !== 16'd2 || short_a !== 4'b0000) begin
            n_err++; $display("FAIL handover_onset_short: got %0d/%b, want 2/0000", onset_a, short_a);
        end
        n_vec++;
        if (obs_b !== exp_b()) begin
            n_err++; $display("FAIL handover_b: got %h, want %h", obs_b, exp_b());
        end
    endtask

    task automatic test_short_green();
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        n_vec++;
        if (short_a !== 4'b0000) begin
            n_err++; $display("FAIL short_early: got %b, want 0000", short_a);
        end
        step(4'b0000, 1'b0);
        n_vec++;
        if (short_a !== 4'b0100 || short_b !== 4'b0000) begin
            n_err++; $display("FAIL short_one_cycle: got %b/%b, want 0100/0000", short_a, short_b);
        end
        step(4'b0000, 1'b1);
        repeat (2) step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        n_vec++;
        if (short_a !== 4'b0000) begin
            n_err++; $display("FAIL short_two_cycle: got %b, want 0000", short_a);
        end
        n_vec++;
        if (obs_a !== exp_a()) begin
            n_err++; $display("FAIL short_model_a: got %h, want %h", obs_a, exp_a());
        end
    endtask

    task automatic test_conflict();
        drive(4'b1001, 1'b0);
        #1;
        n_vec++;
        if (conflict_now_a !== 1'b1 || conflict_a !== 1'b0) begin
            n_err++; $display("FAIL conflict_same_cycle: got now=%b sticky=%b, want 1/0", conflict_now_a, conflict_a);
        end
        tick();
        n_vec++;
        if (conflict_a !== 1'b1 || conflict_b !== 1'b1) begin
            n_err++; $display("FAIL conflict_next: got %b/%b, want 1/1", conflict_a, conflict_b);
        end
        step(4'b0000, 1'b0);
        n_vec++;
        if (conflict_a !== 1'b1 || conflict_now_a !== 1'b0) begin
            n_err++; $display("FAIL conflict_hold: got sticky=%b now=%b, want 1/0", conflict_a, conflict_now_a);
        end
    endtask

    task automatic test_all_pairs();
        int seq [13] = '{0, 1, 2, 3, 0, 2, 1, 3, 2, 0, 3, 1, 0};
        logic [3:0] g;
        step(4'b0000, 1'b1);
        for (int k = 0; k < 13; k++) begin
            g = 4'b0001 << seq[k];
            repeat (2) begin
                step(g, 1'b0);
                n_vec++;
                if (obs_a !== exp_a()) begin
                    n_err++; $display("FAIL all_pairs_a step %0d: got %h, want %h", k, obs_a, exp_a());
                end
                n_vec++;
                if (obs_b !== exp_b()) begin
                    n_err++; $display("FAIL all_pairs_b step %0d: got %h, want %h", k, obs_b, exp_b());
                end
            end
        end
        n_vec++;
        if (pair_seen_a !== 16'h7BDE || all_pairs_a !== 1'b1 || all_pairs_b !== 1'b1) begin
            n_err++; $display("FAIL all_pairs_final: got %h %b %b, want 7bde 1 1", pair_seen_a, all_pairs_a, all_pairs_b);
        end
        step(4'b0001, 1'b1);
        n_vec++;
        if (obs_a !== 38'h0 || obs_b !== 24'h0) begin
            n_err++; $display("FAIL clear_all: got %h/%h, want 0/0", obs_a, obs_b);
        end
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        n_vec++;
        if (onset_a !== 16'd0 || short_a !== 4'b0000 || short_b !== 4'b0000) begin
            n_err++; $display("FAIL clear_in_progress: got onset %0d short %b/%b, want 0 0000/0000", onset_a, short_a, short_b);
        end
    endtask

    task automatic test_saturation();
        step(4'b0000, 1'b1);
        repeat (4) begin
            step(4'b0001, 1'b0);
            step(4'b0000, 1'b0);
        end
        n_vec++;
        if (onset_b !== 2'd3 || onset_a !== 16'd4) begin
            n_err++; $display("FAIL sat_four: got %0d/%0d, want 3/4", onset_b, onset_a);
        end
        step(4'b1111, 1'b0);
        n_vec++;
        if (onset_b !== 2'd3 || onset_a !== 16'd8) begin
            n_err++; $display("FAIL sat_hold: got %0d/%0d, want 3/8", onset_b, onset_a);
        end
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b1111, 1'b0);
        n_vec++;
        if (onset_b !== 2'd3 || onset_a !== 16'd5) begin
            n_err++; $display("FAIL sat_multi_add: got %0d/%0d, want 3/5", onset_b, onset_a);
        end
    endtask

    task automatic test_random();
        logic [3:0] g;
        logic       c;
        g = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 5))
                0, 1:    g = 4'b0001 << $urandom_range(0, 3);
                2:       g = 4'($urandom_range(0, 15));
                3:       g = 4'b0000;
                default: g = g;
            endcase
            c = ($urandom_range(0, 24) == 0);
            drive(g, c);
            #1;
            n_vec++;
            if (conflict_now_a !== exp_cn(g) || conflict_now_b !== exp_cn(g)) begin
                n_err++; $display("FAIL rand_conflict_now %0d: got %b/%b, want %b", k, conflict_now_a, conflict_now_b, exp_cn(g));
            end
            tick();
            n_vec++;
            if (obs_a !== exp_a()) begin
                n_err++; $display("FAIL rand_a %0d: got %h, want %h", k, obs_a, exp_a());
            end
            n_vec++;
            if (obs_b !== exp_b()) begin
                n_err++; $display("FAIL rand_b %0d: got %h, want %h", k, obs_b, exp_b());
            end
        end
    endtask

    task automatic test_async_reset();
        step(4'b0010, 1'b0);
        step(4'b1000, 1'b0);
        drive(4'b0000, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (obs_a !== 38'h0 || obs_b !== 24'h0 || conflict_now_a !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got %h/%h now=%b, want 0/0/0", obs_a, obs_b, conflict_now_a);
        end
        tick();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) step(4'b0010, 1'b0);
        n_vec++;
        if (obs_a !== exp_a() || onset_a !== 16'd1) begin
            n_err++; $display("FAIL after_reset: got %h, want %h", obs_a, exp_a());
        end
    endtask

    initial begin
        test_reset();
        test_handover();
        test_short_green();
        test_conflict();
        test_all_pairs();
        test_saturation();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
